// File: rtl/fan_pkg.sv
// Shared definitions for the fan PWM driver: FSM encodings, slot/level sizes
// and the one-step ramp helper.
package fan_pkg;

  localparam int SLOTS     = 16;
  localparam int SLOT_W    = $clog2(SLOTS);
  localparam int LEVEL_MAX = 15;
  localparam int CRS_W     = 4;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [CRS_W-1:0]  level_t;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_KICK  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } fan_state_e;

  // One step toward the target; the target is itself 0..15, so this never wraps.
  function automatic level_t step_toward(input level_t cur, input level_t tgt);
    if (cur < tgt) return cur + level_t'(1);
    if (cur > tgt) return cur - level_t'(1);
    return cur;
  endfunction

endpackage

// File: rtl/tach_sync_edge.sv
// Brings the asynchronous tachometer pulse into the clk domain and emits a
// one-cycle pulse on each rising edge.
module tach_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tach_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchronizer followed by a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so each flop captures its neighbour's pre-edge value.
      sync1_q <= tach_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Only sync2_q and later are used; sync1_q may be metastable.
  assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/fan_pwm_driver.sv
// Turns the 4-bit fan speed code into a PWM drive with a spin-up kick, a
// gradual ramp toward the target and tachometer-based stall detection.
module fan_pwm_driver
  import fan_pkg::*;
#(
  parameter int PRESCALE      = 4,
  parameter int KICK_PERIODS  = 8,
  parameter int RAMP_PERIODS  = 4,
  parameter int STALL_PERIODS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CRS_W-1:0] crs_i,
  input  logic             tach_i,
  output logic             pwm_o,
  output logic [CRS_W-1:0] level_o,
  output logic [1:0]       state_o,
  output logic             stall_o
);

  localparam int PW = $clog2(PRESCALE) + 1;
  localparam int KW = $clog2(KICK_PERIODS) + 1;
  localparam int RW = $clog2(RAMP_PERIODS) + 1;
  localparam int SW = $clog2(STALL_PERIODS) + 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [KW-1:0] KICK_LAST  = KW'(KICK_PERIODS);
  localparam logic [RW-1:0] RAMP_LAST  = RW'(RAMP_PERIODS);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIODS);
  localparam slot_t         SLOT_LAST  = slot_t'(SLOTS - 1);

  logic [PW-1:0] presc_q;
  slot_t         slot_q;
  level_t        crs_q;
  logic          pwm_q;

  fan_state_e    state_q, state_d;
  level_t        level_q, level_d;
  logic [KW-1:0] kick_q,  kick_d;
  logic [RW-1:0] ramp_q,  ramp_d;
  logic [SW-1:0] stall_q, stall_d;

  logic          tach_edge;
  logic          pb;
  logic          stalled;
  logic [KW-1:0] kick_inc;
  logic [RW-1:0] ramp_inc;
  logic [SW-1:0] stall_inc;

  tach_sync_edge u_tach (
    .clk    (clk),
    .rst    (rst),
    .tach_i (tach_i),
    .edge_o (tach_edge)
  );

  assign pb        = (presc_q == PRESC_LAST) && (slot_q == SLOT_LAST);
  assign kick_inc  = kick_q + KW'(1);
  assign ramp_inc  = ramp_q + RW'(1);
  assign stall_inc = stall_q + SW'(1);

  // Slot timebase, crs input register and the registered PWM comparator.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      slot_q  <= '0;
      crs_q   <= '0;
      pwm_q   <= 1'b0;
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        slot_q  <= slot_q + slot_t'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      crs_q <= crs_i;
      pwm_q <= (slot_q < level_q);
    end
  end

  // FSM state, applied level and the kick/ramp/stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      level_q <= '0;
      kick_q  <= '0;
      ramp_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      kick_q  <= kick_d;
      ramp_q  <= ramp_d;
      stall_q <= stall_d;
    end
  end

  // Next state: stall supervision every cycle, state and level moves on a PB only.
  always_comb begin
    // NOTE: defaults first so every path assigns every _d signal (no latches).
    state_d = state_q;
    level_d = level_q;
    kick_d  = kick_q;
    ramp_d  = ramp_q;
    stall_d = stall_q;
    stalled = 1'b0;

    // A tach edge clears the counter even on a PB; only a spinning RUN counts.
    if (tach_edge) begin
      stall_d = '0;
    end else if (state_q != ST_RUN || level_q == '0) begin
      stall_d = '0;
    end else if (pb) begin
      stall_d = stall_inc;
      stalled = (stall_inc == STALL_LAST);
    end

    if (pb) begin
      unique case (state_q)
        ST_OFF: begin
          if (crs_q != '0) begin
            state_d = ST_KICK;
            level_d = level_t'(LEVEL_MAX);
            kick_d  = '0;
          end
        end
        ST_KICK: begin
          kick_d = kick_inc;
          if (crs_q == '0 || kick_inc == KICK_LAST) begin
            state_d = ST_RUN;
            ramp_d  = '0;
          end
        end
        ST_RUN: begin
          if (stalled) begin
            state_d = ST_STALL;
            level_d = '0;
          end else if (level_q == '0 && crs_q == '0) begin
            state_d = ST_OFF;
          end else if (ramp_inc == RAMP_LAST) begin
            ramp_d  = '0;
            level_d = step_toward(level_q, crs_q);
          end else begin
            ramp_d = ramp_inc;
          end
        end
        ST_STALL: begin
          level_d = '0;
          if (crs_q == '0) state_d = ST_OFF;
        end
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    state_o = state_q;
    stall_o = (state_q == ST_STALL);
  end

  assign pwm_o   = pwm_q;
  assign level_o = level_q;

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Directed bench for fan_pwm_driver. Stimulus runs whole PWM periods and
// queues the state/level expected after each period boundary; a monitor pops
// and compares after every boundary and also checks the PWM duty of the
// period that just ended.
module tb_fan_pwm_driver;
  import fan_pkg::*;

  typedef enum {T_HOLD, T_TOG, T_COINC} tach_mode_e;

  typedef struct {
    fan_state_e st;
    level_t     lvl;
    int         idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] crs_i = 4'd9;
  logic       tach_i = 1'b0;
  logic       pwm_o;
  logic [3:0] level_o;
  logic [1:0] state_o;
  logic       stall_o;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pcount = 0;
  int   pwm_cnt = 0;
  int   prev_level = 0;
  exp_t exp_q[$];

  fan_pwm_driver #(
    .PRESCALE      (1),
    .KICK_PERIODS  (2),
    .RAMP_PERIODS  (1),
    .STALL_PERIODS (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .crs_i   (crs_i),
    .tach_i  (tach_i),
    .pwm_o   (pwm_o),
    .level_o (level_o),
    .state_o (state_o),
    .stall_o (stall_o)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; with PRESCALE = 1 a boundary lands on every 16th.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: accumulate PWM highs, compare state after each period boundary.
  always @(negedge clk) begin
    if (rst) begin
      pwm_cnt    = 0;
      prev_level = 0;
    end else if (cyc != 0) begin
      pwm_cnt += int'(pwm_o);
      if (cyc % 16 == 0) begin
        check("pwm_duty", pwm_cnt, prev_level);
        pwm_cnt = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_pb", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("p%0d_state", e.idx), state_o, e.st);
          check($sformatf("p%0d_level", e.idx), level_o, e.lvl);
          check($sformatf("p%0d_stall", e.idx), stall_o, e.st == ST_STALL);
          prev_level = int'(e.lvl);
        end
      end
    end
  end

  // One PWM period of stimulus; queues the outcome of its closing boundary.
  task automatic do_period(input logic [3:0] crs, input tach_mode_e mode,
                           input fan_state_e st, input level_t lvl);
    exp_t e;
    crs_i  = crs;
    tach_i = (mode == T_TOG);
    e.st   = st;
    e.lvl  = lvl;
    e.idx  = pcount++;
    exp_q.push_back(e);
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1;
      if (mode == T_TOG && j == 7) tach_i = 1'b0;
      // Rising edge reaches the detector in the boundary cycle itself.
      if (mode == T_COINC && j == 12) tach_i = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_level"}, level_o, 0);
    check({tag, "_pwm"}, pwm_o, 0);
    check({tag, "_stall"}, stall_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset with a nonzero code waiting: outputs stay clear.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    do_period(4'd9, T_TOG, ST_KICK, 4'd15);

    // Reset pulsed in the middle of a kick.
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midkick_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    do_period(4'd0, T_HOLD, ST_OFF, 4'd0);

    // Start at 4: two kick periods, then ramp 15 down to 4 and hold.
    do_period(4'd4, T_TOG, ST_KICK, 4'd15);
    do_period(4'd4, T_TOG, ST_KICK, 4'd15);
    do_period(4'd4, T_TOG, ST_RUN, 4'd15);
    for (int l = 14; l >= 4; l--) do_period(4'd4, T_TOG, ST_RUN, level_t'(l));
    do_period(4'd4, T_TOG, ST_RUN, 4'd4);

    // Raise to 8: one step per period, then hold.
    for (int l = 5; l <= 8; l++) do_period(4'd8, T_TOG, ST_RUN, level_t'(l));
    do_period(4'd8, T_TOG, ST_RUN, 4'd8);

    // Tach stops: the boundary above counted 1, three more reach 4.
    do_period(4'd8, T_HOLD, ST_RUN, 4'd8);
    do_period(4'd8, T_HOLD, ST_RUN, 4'd8);
    do_period(4'd8, T_HOLD, ST_STALL, 4'd0);
    do_period(4'd8, T_HOLD, ST_STALL, 4'd0);
    do_period(4'd0, T_HOLD, ST_OFF, 4'd0);

    // Up to 6, then down to 0 and OFF; tach stops at level 2 without a stall.
    do_period(4'd6, T_TOG, ST_KICK, 4'd15);
    do_period(4'd6, T_TOG, ST_KICK, 4'd15);
    do_period(4'd6, T_TOG, ST_RUN, 4'd15);
    for (int l = 14; l >= 6; l--) do_period(4'd6, T_TOG, ST_RUN, level_t'(l));
    for (int l = 5; l >= 2; l--) do_period(4'd0, T_TOG, ST_RUN, level_t'(l));
    do_period(4'd0, T_HOLD, ST_RUN, 4'd1);
    do_period(4'd0, T_HOLD, ST_RUN, 4'd0);
    do_period(4'd0, T_HOLD, ST_OFF, 4'd0);
    do_period(4'd0, T_HOLD, ST_OFF, 4'd0);

    // Tach edge on the 4th boundary clears the counter; four more stall it.
    do_period(4'd3, T_TOG, ST_KICK, 4'd15);
    do_period(4'd3, T_TOG, ST_KICK, 4'd15);
    do_period(4'd3, T_TOG, ST_RUN, 4'd15);
    for (int l = 14; l >= 3; l--) do_period(4'd3, T_TOG, ST_RUN, level_t'(l));
    do_period(4'd3, T_HOLD, ST_RUN, 4'd3);
    do_period(4'd3, T_HOLD, ST_RUN, 4'd3);
    do_period(4'd3, T_COINC, ST_RUN, 4'd3);
    do_period(4'd3, T_HOLD, ST_RUN, 4'd3);
    do_period(4'd3, T_HOLD, ST_RUN, 4'd3);
    do_period(4'd3, T_HOLD, ST_RUN, 4'd3);
    do_period(4'd3, T_HOLD, ST_STALL, 4'd0);
    do_period(4'd0, T_HOLD, ST_OFF, 4'd0);

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
